// File: rtl/pipe_ex_pkg.sv
// Shared definitions for the execute stage: ALU operation codes and multiplier FSM encoding.
// Imported by pipe_ex, pipe_ex_mul and the bench.
package pipe_ex_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    typedef enum logic [0:0] {
        MUL_IDLE = 1'b0,
        MUL_RUN  = 1'b1
    } mul_state_e;

endpackage

// File: rtl/pipe_ex_if.sv
// ID/EX field bundle into the execute stage and EX/MEM register bundle out of it.
// master = decode/memory side, slave = pipe_ex.
interface pipe_ex_if #(parameter int DATA_W = 32);
    logic              EXwreg;
    logic              EXm2reg;
    logic              EXwmem;
    logic [3:0]        EXaluc;
    logic              EXshift;
    logic              EXaluimm;
    logic [4:0]        EXwn;
    logic [DATA_W-1:0] EXqa;
    logic [DATA_W-1:0] EXqb;
    logic [DATA_W-1:0] EXimmeOrSa;
    logic              EXbusy;
    logic              MEMwreg;
    logic              MEMm2reg;
    logic              MEMwmem;
    logic [DATA_W-1:0] MEMalu;
    logic [DATA_W-1:0] MEMdata;
    logic [4:0]        MEMwn;

    modport master (
        output EXwreg, EXm2reg, EXwmem, EXaluc, EXshift, EXaluimm, EXwn,
               EXqa, EXqb, EXimmeOrSa,
        input  EXbusy, MEMwreg, MEMm2reg, MEMwmem, MEMalu, MEMdata, MEMwn
    );

    modport slave (
        input  EXwreg, EXm2reg, EXwmem, EXaluc, EXshift, EXaluimm, EXwn,
               EXqa, EXqb, EXimmeOrSa,
        output EXbusy, MEMwreg, MEMm2reg, MEMwmem, MEMalu, MEMdata, MEMwn
    );
endinterface

// File: rtl/pipe_ex_mul.sv
// Iterative shift-add multiplier for the execute stage: one partial-product step per cycle,
// DATA_W steps after a one-cycle operand load. Drives the stage busy/stall signal.
module pipe_ex_mul
    import pipe_ex_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic [DATA_W-1:0] prod_o
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    mul_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] prod_q, prod_d;
    logic [DATA_W-1:0] step_prod;
    logic              last;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= MUL_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

    // Final step's sum is presented combinationally so it lands in EX/MEM on the same edge.
    assign step_prod = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign last      = (state_q == MUL_RUN) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        unique case (state_q)
            MUL_IDLE: begin
                if (start_i) begin
                    mcand_d  = a_i;
                    mplier_d = b_i;
                    prod_d   = '0;
                    cnt_d    = '0;
                    state_d  = MUL_RUN;
                end
            end
            MUL_RUN: begin
                prod_d   = step_prod;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (last) begin
                    cnt_d   = '0;
                    state_d = MUL_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    // Held low during reset so decode is never stalled by a stale MUL opcode.
    assign busy_o = clrn && start_i && !last;
    assign prod_o = step_prod;

endmodule

// File: rtl/pipe_ex.sv
// Execute stage: operand select, ALU, EX/MEM register. With PIPE_EX_MUL_EN defined an iterative
// multiplier (pipe_ex_mul) handles aluc 1000 and stalls decode via EXbusy; otherwise 1000 is ADD.
module pipe_ex
    import pipe_ex_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic     clk,
    input  logic     clrn,
    pipe_ex_if.slave ex
);

    logic [DATA_W-1:0] opa, opb, alu_res, ex_res;
    logic              busy;

    logic              wreg_q, wreg_d;
    logic              m2reg_q, m2reg_d;
    logic              wmem_q, wmem_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [4:0]        wn_q, wn_d;

    assign opa = ex.EXshift  ? ex.EXimmeOrSa : ex.EXqa;
    assign opb = ex.EXaluimm ? ex.EXimmeOrSa : ex.EXqb;

    always_comb begin
        alu_res = opa + opb;
        unique case (ex.EXaluc)
            ALU_SUB: alu_res = opa - opb;
            ALU_AND: alu_res = opa & opb;
            ALU_OR:  alu_res = opa | opb;
            ALU_XOR: alu_res = opa ^ opb;
            ALU_LUI: alu_res = opb << 16;
            ALU_SLL: alu_res = opb << opa[4:0];
            ALU_SRL: alu_res = opb >> opa[4:0];
            ALU_SRA: alu_res = DATA_W'($signed(opb) >>> opa[4:0]);
            default: alu_res = opa + opb;
        endcase
    end

`ifdef PIPE_EX_MUL_EN
    logic              mul_op;
    logic [DATA_W-1:0] mul_prod;

    assign mul_op = (ex.EXaluc == ALU_MUL);

    pipe_ex_mul #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .clrn    (clrn),
        .start_i (mul_op),
        .a_i     (opa),
        .b_i     (opb),
        .busy_o  (busy),
        .prod_o  (mul_prod)
    );

    assign ex_res = mul_op ? mul_prod : alu_res;
`else
    assign busy   = 1'b0;
    assign ex_res = alu_res;
`endif

    // A stalled cycle pushes an all-zero bubble so nothing downstream writes.
    always_comb begin
        wreg_d  = 1'b0;
        m2reg_d = 1'b0;
        wmem_d  = 1'b0;
        alu_d   = '0;
        data_d  = '0;
        wn_d    = '0;
        if (!busy) begin
            wreg_d  = ex.EXwreg;
            m2reg_d = ex.EXm2reg;
            wmem_d  = ex.EXwmem;
            alu_d   = ex_res;
            data_d  = ex.EXqb;
            wn_d    = ex.EXwn;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wreg_q  <= 1'b0;
            m2reg_q <= 1'b0;
            wmem_q  <= 1'b0;
            alu_q   <= '0;
            data_q  <= '0;
            wn_q    <= '0;
        end else begin
            wreg_q  <= wreg_d;
            m2reg_q <= m2reg_d;
            wmem_q  <= wmem_d;
            alu_q   <= alu_d;
            data_q  <= data_d;
            wn_q    <= wn_d;
        end
    end

    assign ex.EXbusy   = busy;
    assign ex.MEMwreg  = wreg_q;
    assign ex.MEMm2reg = m2reg_q;
    assign ex.MEMwmem  = wmem_q;
    assign ex.MEMalu   = alu_q;
    assign ex.MEMdata  = data_q;
    assign ex.MEMwn    = wn_q;

endmodule
